hdmi_wave_render: RTL and testbench

HDMI_WAVE_RENDER -- requirements
Module: hdmi_wave_render

---
 rtl/hdmi_pkg.sv | 21 ++
 rtl/wave_dpram.sv | 35 +++
 rtl/hdmi_wave_render.sv | 157 +++++++++++++++
 tb/tb_hdmi_wave_render.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI waveform renderer.
// Contents: active-area geometry, waveform column count, trace centre row,
// pixel colours, and the sample-writer FSM state type.
package hdmi_pkg;

  localparam int unsigned H_ACTIVE  = 1920;
  localparam int unsigned V_ACTIVE  = 1080;
  localparam int unsigned WAVE_COLS = 480;
  localparam int unsigned Y_CENTER  = 540;

  localparam logic [23:0] TRACE_RGB = 24'h64FFFA;
  localparam logic [23:0] AXIS_RGB  = 24'h404040;
  localparam logic [23:0] BG_RGB    = 24'h000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL
  } wr_state_e;

endpackage

// File: rtl/wave_dpram.sv
// Simple dual-port RAM holding two waveform banks of WAVE_COLS x 9-bit levels.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address {bank, col}
//   wdata_i  - write data (9-bit signed level)
//   raddr_i  - read address {bank, col}
//   rdata_o  - registered read data, valid one cycle after raddr_i
// Contents are not reset.
module wave_dpram
  import hdmi_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [9:0] waddr_i,
  input  logic [8:0] wdata_i,
  input  logic [9:0] raddr_i,
  output logic [8:0] rdata_o
);

  logic [8:0] mem_q [0:2*WAVE_COLS-1];

  // Bank B starts right after bank A so the array is exactly 2*WAVE_COLS deep.
  function automatic logic [9:0] to_index(input logic [9:0] addr);
    return addr[9] ? 10'(WAVE_COLS) + {1'b0, addr[8:0]} : {1'b0, addr[8:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[to_index(waddr_i)] <= wdata_i;
    end
    rdata_o <= mem_q[to_index(raddr_i)];
  end

endmodule

// File: rtl/hdmi_wave_render.sv
// Renders a double-buffered audio waveform over the HDMI active area.
// Ports:
//   clk, rst                       - pixel clock, async active-low reset
//   px_x, px_y                     - active-area pixel coordinates
//   data_en, h_sync, v_sync        - timing strobes (active-high)
//   smp_valid, smp_data, smp_ready - signed 16-bit sample handshake
//   freeze                         - inhibits bank swaps while high
//   out_data                       - RGB pixel, 2 cycles after the inputs
//   out_h_sync/out_v_sync/out_data_en - strobes aligned with out_data
//   frame_swaps                    - wrapping count of bank swaps
module hdmi_wave_render
  import hdmi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] px_x,
  input  logic [11:0] px_y,
  input  logic        data_en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  output logic        smp_ready,
  input  logic        freeze,
  output logic [23:0] out_data,
  output logic        out_h_sync,
  output logic        out_v_sync,
  output logic        out_data_en,
  output logic [15:0] frame_swaps
);

  wr_state_e   state_q;
  logic        smp_ready_q;
  logic [8:0]  wr_addr_q;
  logic        disp_bank_q;
  logic [15:0] swaps_q;

  logic        de_s1_q, hs_s1_q, vs_s1_q;
  logic [11:0] py_s1_q;
  logic [23:0] out_data_q;
  logic        out_de_q, out_hs_q, out_vs_q;

  logic        accept, vs_rise, swap, last_col;
  logic [8:0]  rd_col;
  logic [8:0]  rd_level;
  logic [11:0] y_trace;
  logic [12:0] y_diff;
  logic        near_trace;
  logic [23:0] pix_d;
  logic        unused_smp_lsbs;

  assign unused_smp_lsbs = ^smp_data[6:0];

  assign accept   = smp_valid && smp_ready_q;
  assign last_col = (wr_addr_q == 9'(WAVE_COLS - 1));
  // vs_s1_q doubles as the v_sync edge register and the first strobe stage.
  assign vs_rise  = v_sync && !vs_s1_q;
  assign swap     = vs_rise && (state_q == ST_FULL) && !freeze;

  // smp_ready is registered and only rises one cycle after entering FILL, so
  // it always implies the FSM is in FILL and drops on the final accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      smp_ready_q <= 1'b0;
      wr_addr_q   <= '0;
      disp_bank_q <= 1'b0;
      swaps_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q     <= ST_FILL;
          smp_ready_q <= 1'b0;
        end
        ST_FILL: begin
          smp_ready_q <= !(accept && last_col);
          if (accept) begin
            if (last_col) begin
              state_q <= ST_FULL;
            end else begin
              wr_addr_q <= wr_addr_q + 9'd1;
            end
          end
        end
        ST_FULL: begin
          smp_ready_q <= 1'b0;
          if (swap) begin
            state_q     <= ST_FILL;
            disp_bank_q <= !disp_bank_q;
            wr_addr_q   <= '0;
            swaps_q     <= swaps_q + 16'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          smp_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_col = (px_x >= 12'(H_ACTIVE)) ? 9'(WAVE_COLS - 1) : px_x[10:2];

  wave_dpram u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i ({!disp_bank_q, wr_addr_q}),
    .wdata_i (smp_data[15:7]),
    .raddr_i ({disp_bank_q, rd_col}),
    .rdata_o (rd_level)
  );

  assign y_trace    = 12'(Y_CENTER) - {{3{rd_level[8]}}, rd_level};
  assign y_diff     = {1'b0, py_s1_q} - {y_trace[11], y_trace};
  assign near_trace = (y_diff == 13'd0) || (y_diff == 13'd1) || (y_diff == '1);

  always_comb begin
    pix_d = BG_RGB;
    if (!de_s1_q) begin
      pix_d = '0;
    end else if (near_trace) begin
      pix_d = TRACE_RGB;
    end else if (py_s1_q == 12'(Y_CENTER)) begin
      pix_d = AXIS_RGB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_s1_q    <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      py_s1_q    <= '0;
      out_data_q <= '0;
      out_de_q   <= 1'b0;
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
    end else begin
      de_s1_q    <= data_en;
      hs_s1_q    <= h_sync;
      vs_s1_q    <= v_sync;
      py_s1_q    <= px_y;
      out_data_q <= pix_d;
      out_de_q   <= de_s1_q;
      out_hs_q   <= hs_s1_q;
      out_vs_q   <= vs_s1_q;
    end
  end

  assign smp_ready   = smp_ready_q;
  assign out_data    = out_data_q;
  assign out_data_en = out_de_q;
  assign out_h_sync  = out_hs_q;
  assign out_v_sync  = out_vs_q;
  assign frame_swaps = swaps_q;

endmodule

// File: tb/tb_hdmi_wave_render.sv
// Directed bench for hdmi_wave_render: reset, fill/swap, extremes,
// simultaneous last-sample/v_sync, freeze, and strobe latency.
module tb_hdmi_wave_render;

  localparam logic [23:0] TRC = 24'h64FFFA;
  localparam logic [23:0] AXS = 24'h404040;
  localparam logic [23:0] BLK = 24'h000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] px_x = '0, px_y = '0;
  logic        data_en = 1'b0, h_sync = 1'b0, v_sync = 1'b0;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data = '0;
  logic        smp_ready;
  logic        freeze = 1'b0;
  logic [23:0] out_data;
  logic        out_h_sync, out_v_sync, out_data_en;
  logic [15:0] frame_swaps;

  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  hdmi_wave_render dut (
    .clk         (clk),
    .rst         (rst),
    .px_x        (px_x),
    .px_y        (px_y),
    .data_en     (data_en),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ready   (smp_ready),
    .freeze      (freeze),
    .out_data    (out_data),
    .out_h_sync  (out_h_sync),
    .out_v_sync  (out_v_sync),
    .out_data_en (out_data_en),
    .frame_swaps (frame_swaps)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one sample, waiting (bounded) for smp_ready, then lets it be accepted.
  task automatic feed(input logic [15:0] d);
    int guard;
    smp_valid = 1'b1;
    smp_data  = d;
    guard     = 0;
    while (!smp_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      ncmp++;
      nerr++;
      $display("FAIL ready_timeout: smp_ready stayed 0 for %0d cycles, required 1", guard);
    end
    step();
    smp_valid = 1'b0;
  endtask

  task automatic fill(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) feed(d);
  endtask

  task automatic vpulse();
    v_sync = 1'b1;
    step();
    v_sync = 1'b0;
    step();
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] exp, input string tag);
    px_x    = 12'(x);
    px_y    = 12'(y);
    data_en = 1'b1;
    step();
    data_en = 1'b0;
    step();
    chk($sformatf("%s x=%0d y=%0d", tag, x, y), {8'h0, out_data}, {8'h0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int xs [8];
    xs = '{0, 1, 3, 4, 479, 1000, 1916, 1919};

    // Bring up, then partially fill so the following reset must discard it.
    repeat (3) step();
    rst = 1'b1;
    step();
    fill(100, 16'h1234);

    // Reset for 5 cycles with h_sync and data_en toggling.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      h_sync  = ~h_sync;
      data_en = ~data_en;
      step();
    end
    h_sync  = 1'b0;
    data_en = 1'b0;
    chk("rst out_data", {8'h0, out_data}, 32'h0);
    chk("rst out_h_sync", {31'h0, out_h_sync}, 32'h0);
    chk("rst out_v_sync", {31'h0, out_v_sync}, 32'h0);
    chk("rst out_data_en", {31'h0, out_data_en}, 32'h0);
    chk("rst frame_swaps", {16'h0, frame_swaps}, 32'h0);
    chk("rst smp_ready", {31'h0, smp_ready}, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ready 1 cycle after release", {31'h0, smp_ready}, 32'h0);
    step();
    chk("ready 2 cycles after release", {31'h0, smp_ready}, 32'h1);

    // Fill restarts at column 0: still ready after 479, full after 480.
    fill(479, 16'h0000);
    chk("ready after 479", {31'h0, smp_ready}, 32'h1);
    feed(16'h0000);
    chk("ready after 480", {31'h0, smp_ready}, 32'h0);
    chk("swaps before vsync", {16'h0, frame_swaps}, 32'h0);
    vpulse();
    chk("swaps after first swap", {16'h0, frame_swaps}, 32'h1);

    // Flat zero trace: rows 539..541 lit across the whole width.
    for (int i = 0; i < 8; i++) begin
      for (int y = 538; y <= 542; y++) begin
        pix(xs[i], y, (y >= 539 && y <= 541) ? TRC : BLK, "zero");
      end
    end
    pix(2000, 540, TRC, "zero beyond width");

    // Extremes: col0 = +255 (y 285), col1 = -256 (y 796), rest +128 (y 412).
    feed(16'h7FFF);
    feed(16'h8000);
    fill(478, 16'h4000);
    vpulse();
    chk("swaps after second swap", {16'h0, frame_swaps}, 32'h2);
    pix(0, 284, TRC, "max");
    pix(3, 286, TRC, "max");
    pix(2, 285, TRC, "max");
    pix(0, 283, BLK, "max");
    pix(3, 287, BLK, "max");
    pix(4, 795, TRC, "min");
    pix(7, 797, TRC, "min");
    pix(4, 794, BLK, "min");
    pix(7, 798, BLK, "min");
    pix(8, 796, BLK, "min next col");
    pix(0, 540, AXS, "axis");
    pix(4, 540, AXS, "axis");
    pix(100, 540, AXS, "axis");
    pix(100, 411, TRC, "mid");
    pix(100, 413, TRC, "mid");
    pix(100, 414, BLK, "mid");
    pix(2000, 413, TRC, "mid beyond width");

    // Last sample accepted on the v_sync rising-edge cycle: no swap yet.
    fill(479, 16'h0000);
    smp_valid = 1'b1;
    smp_data  = 16'h0000;
    for (int g = 0; g < 20 && !smp_ready; g++) step();
    chk("ready before simultaneous", {31'h0, smp_ready}, 32'h1);
    v_sync = 1'b1;
    step();
    smp_valid = 1'b0;
    v_sync    = 1'b0;
    step();
    chk("swaps after simultaneous", {16'h0, frame_swaps}, 32'h2);
    chk("ready after simultaneous", {31'h0, smp_ready}, 32'h0);
    vpulse();
    chk("swaps at following vsync", {16'h0, frame_swaps}, 32'h3);
    pix(100, 540, TRC, "bank B zero");
    pix(100, 412, BLK, "bank B zero");

    // Freeze across 3 v_sync pulses with the back bank full.
    fill(480, 16'h4000);
    freeze = 1'b1;
    repeat (3) vpulse();
    chk("swaps frozen", {16'h0, frame_swaps}, 32'h3);
    chk("ready frozen", {31'h0, smp_ready}, 32'h0);
    pix(100, 540, TRC, "frozen display");
    freeze = 1'b0;
    vpulse();
    chk("swaps after unfreeze", {16'h0, frame_swaps}, 32'h4);
    pix(100, 412, TRC, "unfrozen display");
    pix(100, 540, AXS, "unfrozen display");

    // Single-cycle strobe pulse appears exactly 2 cycles later.
    px_x    = 12'd100;
    px_y    = 12'd412;
    data_en = 1'b1;
    h_sync  = 1'b1;
    v_sync  = 1'b1;
    step();
    data_en = 1'b0;
    h_sync  = 1'b0;
    v_sync  = 1'b0;
    chk("lat+1 out_h_sync", {31'h0, out_h_sync}, 32'h0);
    chk("lat+1 out_data_en", {31'h0, out_data_en}, 32'h0);
    chk("lat+1 out_v_sync", {31'h0, out_v_sync}, 32'h0);
    chk("lat+1 out_data", {8'h0, out_data}, 32'h0);
    step();
    chk("lat+2 out_h_sync", {31'h0, out_h_sync}, 32'h1);
    chk("lat+2 out_data_en", {31'h0, out_data_en}, 32'h1);
    chk("lat+2 out_v_sync", {31'h0, out_v_sync}, 32'h1);
    chk("lat+2 out_data", {8'h0, out_data}, {8'h0, TRC});
    step();
    chk("lat+3 out_h_sync", {31'h0, out_h_sync}, 32'h0);
    chk("lat+3 out_data_en", {31'h0, out_data_en}, 32'h0);
    chk("lat+3 out_v_sync", {31'h0, out_v_sync}, 32'h0);
    chk("lat+3 out_data", {8'h0, out_data}, 32'h0);
    chk("no swap while filling", {16'h0, frame_swaps}, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
